// File: rtl/jtag_host.sv
// JTAG host: turns RESET / SHIFT_IR / SHIFT_DR commands into TCK/TMS/TDI bit slots
// and returns the captured TDO bits right-aligned in rsp_data.
module jtag_host #(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam logic [7:0] DIV_LAST = 8'(TCK_HALF - 1);

  typedef enum logic [2:0] {INIT_TLR, IDLE, PRE, SHIFT, POST, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  div;
  logic [4:0]  cnt, cnt_next;
  logic        tms_next, tdi_next;
  logic        from_cmd;
  logic        is_ir;
  logic [4:0]  len_q;
  logic [31:0] data_q;
  logic        active, accept, rise, slot_end;

  assign active   = (state == INIT_TLR) || (state == PRE) || (state == SHIFT) || (state == POST);
  assign accept   = (state == IDLE) && cmd_ready && cmd_valid;
  assign rise     = active && !tck && (div == DIV_LAST);
  assign slot_end = active && tck && (div == DIV_LAST);

  // Slot sequencing: the next slot's tms/tdi are decided when the current high phase ends.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tms_next   = tms;
    tdi_next   = tdi;
    if (accept) begin
      state_next = (cmd_op == 2'd1 || cmd_op == 2'd2) ? PRE : INIT_TLR;
      cnt_next   = '0;
      tms_next   = 1'b1;
      tdi_next   = 1'b0;
    end else if (state == DONE) begin
      state_next = IDLE;
    end else if (slot_end) begin
      cnt_next = cnt + 5'd1;
      case (state)
        INIT_TLR: if (cnt == 5'd5) begin
          state_next = from_cmd ? DONE : IDLE;
          cnt_next   = '0;
        end
        PRE: if (cnt == (is_ir ? 5'd3 : 5'd2)) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
        SHIFT: if (cnt == len_q) begin
          state_next = POST;
          cnt_next   = '0;
        end
        POST: if (cnt == 5'd1) begin
          state_next = DONE;
          cnt_next   = '0;
        end
        default: ;
      endcase
      tdi_next = 1'b0;
      case (state_next)
        INIT_TLR: tms_next = (cnt_next != 5'd5);
        PRE:      tms_next = (cnt_next == 5'd0) || (is_ir && cnt_next == 5'd1);
        SHIFT: begin
          tms_next = (cnt_next == len_q);
          tdi_next = data_q[cnt_next];
        end
        POST:     tms_next = (cnt_next == 5'd0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_TLR;
      cnt       <= '0;
      div       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      from_cmd  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      tms       <= tms_next;
      tdi       <= tdi_next;
      cmd_ready <= (state == IDLE) && !accept;
      rsp_valid <= (state == DONE);
      if (accept) from_cmd <= 1'b1;
      if (accept) rsp_data <= '0;
      else if (rise && state == SHIFT) rsp_data[cnt] <= tdo;
      if (!active) begin
        div <= '0;
        tck <= 1'b0;
      end else if (div == DIV_LAST) begin
        div <= '0;
        tck <= ~tck;
      end else begin
        div <= div + 8'd1;
      end
    end
  end

  // Command fields are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      len_q  <= cmd_len;
      data_q <= cmd_data;
      is_ir  <= (cmd_op == 2'd1);
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: behavioural TAP target plus a command-level reference model
// for TMS/TDI slot sequences, latency and captured response data.
module tb_jtag_host;
  localparam int TCK_HALF = 2;
  localparam logic [31:0] IDCODE = 32'h1BEEF0FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic rsp_valid;
  logic [31:0] rsp_data;
  logic tck, tms, tdi;
  logic tdo = 1'b0;

  jtag_host #(.TCK_HALF(TCK_HALF)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Behavioural TAP: 4-bit IR, IDCODE (IR=1) and BYPASS (anything else).
  typedef enum {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;
  tap_t ts = PAUDR;
  logic [3:0]  ir_tap = 4'hF;
  logic [3:0]  ir_sr = 4'h0;
  logic [31:0] dr_sr = '0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (ts)
      TLR:   ir_tap <= 4'h1;
      CAPDR: dr_sr <= (ir_tap == 4'h1) ? IDCODE : 32'h0;
      SHDR:  dr_sr <= (ir_tap == 4'h1) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
      UPIR:  ir_tap <= ir_sr;
      default: ;
    endcase
    ts <= tap_next(ts, tms);
  end

  always @(negedge tck)
    tdo <= (ts == SHDR) ? dr_sr[0] : (ts == SHIR) ? ir_sr[0] : 1'b0;

  // Pin monitor: one entry per tck rising edge, plus protocol violation counters.
  bit rec_tms[$];
  bit rec_tdi[$];
  int rsp_cnt = 0;
  int stab_err = 0;
  int idle_err = 0;
  logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tck && !prev_tck) begin
        rec_tms.push_back(tms);
        rec_tdi.push_back(tdi);
      end
      if (tck && prev_tck && (tms !== prev_tms || tdi !== prev_tdi)) stab_err <= stab_err + 1;
      if (cmd_ready && tck) idle_err <= idle_err + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end
    prev_tck <= tck;
    prev_tms <= tms;
    prev_tdi <= tdi;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input bit q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  // Reference model: instruction currently held by the target, as implied by commands issued.
  logic [3:0] ir_ref = 4'h1;
  logic [31:0] last_rsp;

  task automatic expect_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                            output logic [63:0] tv, output logic [63:0] dv,
                            output int slots, output logic [31:0] rsp);
    bit tq[$];
    bit dq[$];
    int n;
    logic [63:0] v, mask;
    n = int'(len) + 1;
    mask = (64'd1 << n) - 64'd1;
    if (op == 2'd1 || op == 2'd2) begin
      tq.push_back(1'b1); dq.push_back(1'b0);
      if (op == 2'd1) begin tq.push_back(1'b1); dq.push_back(1'b0); end
      repeat (2) begin tq.push_back(1'b0); dq.push_back(1'b0); end
      for (int k = 0; k < n; k++) begin
        tq.push_back(k == n - 1);
        dq.push_back(data[k]);
      end
      tq.push_back(1'b1); dq.push_back(1'b0);
      tq.push_back(1'b0); dq.push_back(1'b0);
      if (op == 2'd1) begin
        v = 64'h1 | ({32'h0, data} << 4);
        ir_ref = 4'((v >> n) & 64'hF);
      end else begin
        v = (ir_ref == 4'h1) ? {data, IDCODE} : ({32'h0, data} << 1);
      end
      rsp = 32'(v & mask);
    end else begin
      repeat (5) begin tq.push_back(1'b1); dq.push_back(1'b0); end
      tq.push_back(1'b0); dq.push_back(1'b0);
      rsp = '0;
      ir_ref = 4'h1;
    end
    slots = tq.size();
    tv = pack(tq);
    dv = pack(dq);
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           output int r0);
    int w = 0;
    do begin @(negedge clk); #1; w++; end while (!cmd_ready && w < 500);
    check("ready_before_cmd", cmd_ready, 1);
    rec_tms.delete();
    rec_tdi.delete();
    r0 = rsp_cnt;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 5'($urandom); cmd_data = $urandom;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
    logic [63:0] tv, dv;
    logic [31:0] er;
    int slots, k, r0;
    expect_cmd(op, len, data, tv, dv, slots, er);
    start_cmd(op, len, data, r0);
    k = 0;
    do begin @(posedge clk); k++; #1; end while (!rsp_valid && k < 3000);
    check("latency", k, slots * 2 * TCK_HALF + 1);
    check("rsp_data", rsp_data, er);
    last_rsp = rsp_data;
    check("slot_count", rec_tms.size(), slots);
    check("tms_seq", pack(rec_tms), tv);
    check("tdi_seq", pack(rec_tdi), dv);
    repeat (3) @(negedge clk);
    #1;
    check("single_pulse", rsp_cnt - r0, 1);
    check("rsp_hold", rsp_data, er);
    check("tap_in_rti", ts == RTI, 1);
    check("ready_after", cmd_ready, 1);
  endtask

  task automatic release_init();
    int k = 0;
    int r0;
    rec_tms.delete();
    rec_tdi.delete();
    r0 = rsp_cnt;
    rst = 1'b0;
    do begin @(posedge clk); k++; #1; end while (!cmd_ready && k < 500);
    check("init_ready_clk", k, 6 * 2 * TCK_HALF + 1);
    check("init_slots", rec_tms.size(), 6);
    check("init_tms", pack(rec_tms), 64'h1F);
    check("init_tdi", pack(rec_tdi), 64'h0);
    repeat (2) @(negedge clk);
    #1;
    check("init_no_rsp", rsp_cnt - r0, 0);
    check("init_tap_rti", ts == RTI, 1);
    ir_ref = 4'h1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, acc, got, w;
    logic [63:0] tv, dv;
    logic [31:0] er;
    int slots;
    logic [31:0] exp_q[$];

    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    release_init();

    do_cmd(2'd1, 5'd3, 32'hF);
    do_cmd(2'd2, 5'd7, 32'hA5);
    check("bypass_a5", last_rsp, 32'h4A);

    do_cmd(2'd1, 5'd3, 32'h1);
    do_cmd(2'd2, 5'd31, 32'h0);
    check("idcode", last_rsp, IDCODE);

    do_cmd(2'd2, 5'd0, 32'h1);
    check("n1_upper_zero", last_rsp >> 1, 0);
    check("n1_slots", rec_tms.size(), 6);

    for (int i = 0; i < 8; i++) do_cmd(2'($urandom), 5'($urandom), $urandom);

    // Abort a long DR shift while tck is high.
    do_cmd(2'd1, 5'd3, 32'h1);
    expect_cmd(2'd2, 5'd31, $urandom, tv, dv, slots, er);
    start_cmd(2'd2, 5'd31, 32'h12345678, r0);
    repeat (20) @(posedge clk);
    w = 0;
    do begin @(negedge clk); #1; w++; end while (!tck && w < 20);
    check("abort_tck_high", tck, 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_tck", tck, 0);
    check("abort_tms", tms, 1);
    check("abort_ready", cmd_ready, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_rsp", rsp_cnt - r0, 0);
    release_init();
    do_cmd(2'd2, 5'd31, $urandom);
    check("after_abort_idcode", last_rsp, IDCODE);

    // cmd_valid held high with data changing every cycle.
    do_cmd(2'd1, 5'd3, 32'hF);
    r0 = rsp_cnt; acc = 0; got = 0;
    for (int c = 0; c < 3000 && got < 4; c++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        check("stream_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("stream_rsp", rsp_data, exp_q.pop_front());
        got++;
      end
      if (got < 4) begin
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'($urandom); cmd_data = $urandom;
        if (cmd_ready) begin
          acc++;
          expect_cmd(cmd_op, cmd_len, cmd_data, tv, dv, slots, er);
          exp_q.push_back(er);
        end
      end
    end
    cmd_valid = 1'b0;
    check("stream_responses", got, 4);
    check("stream_accepts", acc, 4);
    check("stream_pulses", rsp_cnt - r0, 4);
    repeat (10) @(negedge clk);
    #1;
    check("stream_no_extra", rsp_cnt - r0, 4);
    check("stream_idle_ready", cmd_ready, 1);

    check("tms_tdi_stable_high", stab_err, 0);
    check("tck_low_when_idle", idle_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 Parameter TCK_HALF, default 2: system clocks per TCK half-period, legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  host idle, command can be accepted.
REQ-006 cmd_op  input  2  operation: 0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=reserved (treated as RESET).
REQ-007 cmd_len  input  5  shift length minus one (1..32 bits).
REQ-008 cmd_data  input  32  TDI bits, LSB shifted first.
REQ-009 rsp_valid  output  1  one-cycle pulse, command complete.
REQ-010 rsp_data  output  32  captured TDO bits, right-aligned.
REQ-011 tck, tms, tdi  output  1 each  JTAG pins to the target TAP.
REQ-012 tdo  input  1  JTAG data from the target TAP.

Function
REQ-013 Command accepted on a clk edge with cmd_valid and cmd_ready both high; cmd_op, cmd_len and cmd_data are registered at that edge.
REQ-014 cmd_ready drops the cycle after acceptance and stays low until the cycle after the rsp_valid pulse; cmd_valid while busy is ignored.
REQ-015 Work is a sequence of bit slots: tms/tdi set at slot start with tck low for TCK_HALF clocks, then tck high for TCK_HALF clocks; tms/tdi never change while tck is high.
REQ-016 tdo is sampled on the clk edge that drives tck from 0 to 1.
REQ-017 FSM states: INIT_TLR, IDLE, PRE, SHIFT, POST, DONE.
REQ-018 RESET op, TMS sequence 1,1,1,1,1,0 (6 slots): ends in Run-Test/Idle; rsp_data=0.
REQ-019 SHIFT_IR op from Run-Test/Idle, TMS sequence:
- PRE: 1,1,0,0 (reaches Shift-IR)
- SHIFT: N slots, TMS=0 except 1 on the last (to Exit1)
- POST: 1,0 (Update, then Idle)
- total N+6 slots
REQ-020 SHIFT_DR op: PRE is 1,0,0; SHIFT and POST as for SHIFT_IR; total N+5 slots.
REQ-021 Bit values per slot:
- SHIFT slot k (k=0..N-1): tdi=cmd_data[k]; tdo sample stored to rsp_data[k]
- rsp_data[31:N]=0
- tdi=0 in every non-SHIFT slot
REQ-022 Timing of completion:
- rsp_valid pulses for one clk on the edge after the last slot's high phase ends
- rsp_data is held until the next acceptance
- latency from acceptance edge to rsp_valid = slots*2*TCK_HALF+1 clocks
REQ-023 N=1: the single SHIFT slot carries TMS=1.
REQ-024 Bit counter and divider are sized so that N=32 and TCK_HALF=255 do not overflow.
REQ-025 tck is low whenever the FSM is in IDLE.

Reset
REQ-026 While rst is high, all outputs take these values: cmd_ready=0, rsp_valid=0, rsp_data=0, tck=0, tms=1, tdi=0.
REQ-027 After rst deasserts, the FSM enters INIT_TLR and runs the RESET sequence with no rsp_valid; it then reaches IDLE with cmd_ready=1.
REQ-028 rst asserted mid-command aborts the command immediately without a response; the INIT_TLR sequence then resynchronises the TAP.

Verification
REQ-029 Behavioural TAP model; TCK_HALF=2. Release reset -> 6 slots with tms=1,1,1,1,1,0; cmd_ready=1 at clk 25 after release; no rsp_valid.
REQ-030 SHIFT_DR, cmd_len=7, cmd_data=0xA5, target in BYPASS -> rsp_data=0x4A; rsp_valid exactly 13*4+1=53 clocks after acceptance.
REQ-031 SHIFT_IR, cmd_len=3, data=0x1 (IDCODE), then SHIFT_DR, cmd_len=31, data=0 -> second rsp_data equals the model IDCODE 0x1BEEF0FF; the model ends in Run-Test/Idle.
REQ-032 SHIFT_DR, cmd_len=0, data=1 -> tms=1 in the SHIFT slot; total 6 slots; rsp_data[31:1]=0.
REQ-033 Raise rst during the SHIFT phase -> tck=0 within the same cycle; no rsp_valid; after release the INIT_TLR sequence runs, then a new command completes correctly.
REQ-034 Hold cmd_valid high continuously with changing cmd_data -> only values present at cmd_ready edges are executed; every command produces exactly one rsp_valid.
